intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Interrupt controller sitting upstream of the CSR unit.
//  - Synchronises NUM_SRC external interrupt lines, latches pending events and picks the winner by fixed priority.
//  - Gates the request with the CSR_MIE enable and an internal in-service flag.
//  - Issues the single-cycle INT_TAKEN strobe at an instruction boundary. The CSR unit uses it to capture MEPC; the control FSM uses it to redirect the PC to MTVEC.
//  - MRET ends service and re-arms the block.
// PARAMETERS
//  NUM_SRC    4              number of interrupt sources (1..16)
//  EDGE_MASK  {NUM_SRC{1'b1}}  per source: 1 = rising-edge, latched; 0 = level, not latched
//  ID_W       $clog2(NUM_SRC) (min 1)  width of INT_ID (derived; do not override)
// PORTS
//  CLK         in   1        clock
//  RST         in   1        synchronous reset, active-high
//  INTR_IN     in   NUM_SRC  async interrupt lines; bit 0 = highest priority
//  CSR_MIE     in   1        global interrupt enable from the CSR unit
//  INSTR_DONE  in   1        control-FSM strobe, 1 cycle: current instruction retires this cycle
//  MRET        in   1        control-FSM strobe: mret executes this cycle
//  INT_TAKEN   out  1        1-cycle strobe; CSR captures PC and the FSM loads MTVEC on the same edge
//  INT_ID      out  ID_W     index of the source being taken; valid while INT_TAKEN=1, else 0
//  PENDING     out  NUM_SRC  current pending vector (debug / CSR mip readback)
//  IN_SERVICE  out  1        1 from the take edge until the MRET edge
// BEHAVIOUR
//  Reset (RST=1 at a CLK edge):
//   - Synchroniser flops, pending, in_service and prev-sample all cleared.
//   - Outputs while/after reset: INT_TAKEN=0, INT_ID=0, PENDING=0, IN_SERVICE=0.
//   - RST dominates every other input in the same cycle, including mid-service: in_service is dropped, and a pending or taken event is lost.
//  Synchroniser (per bit):
//   - Chain s1<=INTR_IN, s2<=s1, s3<=s2.
//   - rise = s2 & ~s3.
//  Pending (per bit i):
//   - Edge source (EDGE_MASK[i]=1): pend[i] <= pend[i] | rise[i], cleared on the edge where i is taken.
//   - Simultaneous rise[i] and take of i: pend[i] stays 1. The new event is kept.
//   - Level source (EDGE_MASK[i]=0): pend[i] = s2[i] combinationally. It is not cleared by a take; the handler must clear the device.
//   - PENDING = pend vector.
//  Latency:
//   - INTR_IN[i] sampled high at edge k.
//   - Edge source: PENDING[i]=1 after edge k+2.
//   - Level source: PENDING[i]=1 after edge k+1.
//  Take condition (combinational; valid the whole cycle):
//   - INT_TAKEN = INSTR_DONE & CSR_MIE & ~in_service & |PENDING.
//   - INT_ID = index of the lowest set bit of PENDING when INT_TAKEN=1; otherwise 0.
//  State machine, 2 states:
//   - IDLE -> SERVICE on an edge with INT_TAKEN=1.
//   - SERVICE -> IDLE on an edge with MRET=1.
//   - MRET in IDLE is ignored.
//   - IN_SERVICE = (state==SERVICE).
//   - No nesting: in SERVICE, INT_TAKEN is forced 0 regardless of CSR_MIE, and new events keep accumulating in PENDING.
//  Simultaneous events:
//   - MRET and INSTR_DONE in the same SERVICE cycle: no take that cycle. A take is allowed at the next INSTR_DONE.
//   - CSR_MIE=0: pending events are held indefinitely and no take occurs. A take occurs at the first INSTR_DONE after CSR_MIE returns to 1.
//   - INSTR_DONE with PENDING=0: nothing happens.
//  Minimum take spacing: 1 take per MRET, back-to-back service allowed (take at the MRET+1 boundary).
// TESTING
//  T1 Edge: pulse INTR_IN[2] for 1 cycle at edge 0, CSR_MIE=1, INSTR_DONE at cycle 5.
//     -> PENDING=4'b0100 after edge 2; INT_TAKEN=1, INT_ID=2 in cycle 5.
//     -> PENDING=0 and IN_SERVICE=1 after edge 5.
//  T2 Priority: PENDING=4'b1010, INSTR_DONE.
//     -> INT_ID=1.
//     -> MRET, then next INSTR_DONE: INT_ID=3. PENDING=0 after both takes.
//  T3 Mask: CSR_MIE=0, raise INTR_IN[0], 3 INSTR_DONE strobes.
//     -> INT_TAKEN stays 0 and PENDING[0] stays 1.
//     -> Set CSR_MIE=1: take occurs at the next INSTR_DONE.
//  T4 No nesting: in SERVICE, raise INTR_IN[1] with INSTR_DONE toggling.
//     -> INT_TAKEN=0 and PENDING[1]=1.
//     -> MRET+INSTR_DONE in the same cycle: still no take. The following INSTR_DONE takes INT_ID=1.
//  T5 Level: EDGE_MASK=4'b1110, hold INTR_IN[0]=1.
//     -> Take with INT_ID=0, then PENDING[0] stays 1.
//     -> Drop INTR_IN[0]: PENDING[0]=0 two edges later.
//  T6 Reset in SERVICE with PENDING=4'b0110: assert RST for 1 cycle.
//     -> All outputs 0, state IDLE. Stale s1/s2 contents do not produce a spurious rise.

Source files
------------

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - fixed-priority interrupt controller feeding the CSR unit
// Synchronises the lines, latches edge events and strobes INT_TAKEN at an instruction boundary.
module intr_ctrl #(
  parameter int NUM_SRC = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] INTR_IN,
  input  logic               CSR_MIE,
  input  logic               INSTR_DONE,
  input  logic               MRET,
  output logic               INT_TAKEN,
  output logic [ID_W-1:0]    INT_ID,
  output logic [NUM_SRC-1:0] PENDING,
  output logic               IN_SERVICE
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_SERVICE = 1'b1;

  logic [0:0]         state;
  logic [NUM_SRC-1:0] s1, s2, s3;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] win_oh;
  logic [NUM_SRC-1:0] take_oh;
  logic [ID_W-1:0]    win_id;

  assign rise = s2 & ~s3;

  // Level sources follow the synchronised line directly; only edge sources are latched.
  assign PENDING = (pend_q & EDGE_MASK) | (s2 & ~EDGE_MASK);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    win_id = '0;
    win_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (PENDING[i]) begin
        win_id    = ID_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign INT_TAKEN  = INSTR_DONE & CSR_MIE & (state == S_IDLE) & (|PENDING);
  assign INT_ID     = INT_TAKEN ? win_id : '0;
  assign take_oh    = INT_TAKEN ? win_oh : '0;
  assign IN_SERVICE = (state == S_SERVICE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      pend_q <= '0;
      state  <= S_IDLE;
    end else begin
      s1 <= INTR_IN;
      s2 <= s1;
      s3 <= s2;
      // A rise arriving on the take edge survives the clear, so that event is not lost.
      pend_q <= ((pend_q & ~take_oh) | rise) & EDGE_MASK;
      case (state)
        S_IDLE:    if (INT_TAKEN) state <= S_SERVICE;
        S_SERVICE: if (MRET)      state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
// Edge-configured instance for most scenarios, level-on-bit-0 instance for the level scenario.
module tb_intr_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] intr_in;
  logic       csr_mie, instr_done, mret;
  logic       int_taken, in_service;
  logic [1:0] int_id;
  logic [3:0] pending;

  logic [3:0] l_intr_in;
  logic       l_csr_mie, l_instr_done, l_mret;
  logic       l_int_taken, l_in_service;
  logic [1:0] l_int_id;
  logic [3:0] l_pending;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  intr_ctrl #(.NUM_SRC(4)) dut (
    .CLK(CLK), .RST(RST), .INTR_IN(intr_in), .CSR_MIE(csr_mie),
    .INSTR_DONE(instr_done), .MRET(mret), .INT_TAKEN(int_taken),
    .INT_ID(int_id), .PENDING(pending), .IN_SERVICE(in_service)
  );

  intr_ctrl #(.NUM_SRC(4), .EDGE_MASK(4'b1110)) dut_lvl (
    .CLK(CLK), .RST(RST), .INTR_IN(l_intr_in), .CSR_MIE(l_csr_mie),
    .INSTR_DONE(l_instr_done), .MRET(l_mret), .INT_TAKEN(l_int_taken),
    .INT_ID(l_int_id), .PENDING(l_pending), .IN_SERVICE(l_in_service)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; inputs change here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Move to mid-cycle to sample outputs.
  task automatic mid();
    @(negedge CLK);
  endtask

  // One-cycle pulse; PENDING is set two edges after the sampling edge.
  task automatic pulse(input logic [3:0] m);
    intr_in = m;
    tick();
    intr_in = 4'b0;
    tick();
    tick();
  endtask

  task automatic do_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    intr_in = '0; csr_mie = 1'b1; instr_done = 1'b0; mret = 1'b0;
    l_intr_in = '0; l_csr_mie = 1'b1; l_instr_done = 1'b0; l_mret = 1'b0;
    tick(); tick();
    instr_done = 1'b1;
    mid();
    chk("rst_taken", {31'b0, int_taken}, 32'd0);
    chk("rst_id", {30'b0, int_id}, 32'd0);
    chk("rst_pending", {28'b0, pending}, 32'd0);
    chk("rst_in_service", {31'b0, in_service}, 32'd0);
    tick();
    instr_done = 1'b0;
    RST = 1'b0;

    // T1: single-cycle pulse on bit 2, sampled at edge 0
    intr_in = 4'b0100;
    tick();                      // edge 0
    intr_in = 4'b0000;
    tick();                      // edge 1
    mid();
    chk("t1_pend_e1", {28'b0, pending}, 32'h0);
    tick();                      // edge 2
    mid();
    chk("t1_pend_e2", {28'b0, pending}, 32'h4);
    tick(); tick();              // edges 3, 4
    instr_done = 1'b1;
    mid();
    chk("t1_taken", {31'b0, int_taken}, 32'd1);
    chk("t1_id", {30'b0, int_id}, 32'd2);
    tick();                      // edge 5
    instr_done = 1'b0;
    mid();
    chk("t1_pend_after", {28'b0, pending}, 32'h0);
    chk("t1_in_service", {31'b0, in_service}, 32'd1);
    chk("t1_id_idle", {30'b0, int_id}, 32'd0);
    tick();
    do_mret();
    mid();
    chk("t1_mret", {31'b0, in_service}, 32'd0);

    // T2: priority, bit 1 before bit 3, back-to-back after MRET
    tick();
    pulse(4'b1010);
    mid();
    chk("t2_pend", {28'b0, pending}, 32'hA);
    tick();
    instr_done = 1'b1;
    mid();
    chk("t2_id1", {30'b0, int_id}, 32'd1);
    tick();
    instr_done = 1'b0;
    mid();
    chk("t2_pend_mid", {28'b0, pending}, 32'h8);
    tick();
    do_mret();
    instr_done = 1'b1;
    mid();
    chk("t2_taken2", {31'b0, int_taken}, 32'd1);
    chk("t2_id3", {30'b0, int_id}, 32'd3);
    tick();
    instr_done = 1'b0;
    mid();
    chk("t2_pend_end", {28'b0, pending}, 32'h0);
    tick();
    do_mret();

    // T3: masked by CSR_MIE
    csr_mie = 1'b0;
    pulse(4'b0001);
    for (int n = 0; n < 3; n++) begin
      instr_done = 1'b1;
      mid();
      chk("t3_masked_taken", {31'b0, int_taken}, 32'd0);
      tick();
      instr_done = 1'b0;
      mid();
      chk("t3_held_pend", {31'b0, pending[0]}, 32'd1);
      tick();
    end
    csr_mie = 1'b1;
    mid();
    chk("t3_no_done", {31'b0, int_taken}, 32'd0);
    tick();
    instr_done = 1'b1;
    mid();
    chk("t3_taken", {31'b0, int_taken}, 32'd1);
    chk("t3_id", {30'b0, int_id}, 32'd0);
    tick();
    instr_done = 1'b0;

    // T4: no nesting; bit 1 arrives while bit 0 is in service
    intr_in = 4'b0010;
    for (int n = 0; n < 4; n++) begin
      instr_done = n[0];
      mid();
      chk("t4_nest_taken", {31'b0, int_taken}, 32'd0);
      tick();
      intr_in = 4'b0000;
    end
    instr_done = 1'b0;
    mid();
    chk("t4_pend", {31'b0, pending[1]}, 32'd1);
    chk("t4_in_service", {31'b0, in_service}, 32'd1);
    tick();
    mret = 1'b1;
    instr_done = 1'b1;
    mid();
    chk("t4_mret_done", {31'b0, int_taken}, 32'd0);
    tick();
    mret = 1'b0;
    instr_done = 1'b0;
    mid();
    chk("t4_idle", {31'b0, in_service}, 32'd0);
    tick();
    instr_done = 1'b1;
    mid();
    chk("t4_taken", {31'b0, int_taken}, 32'd1);
    chk("t4_id", {30'b0, int_id}, 32'd1);
    tick();
    instr_done = 1'b0;
    do_mret();

    // Rise on the same edge that takes that source: the new event is kept
    pulse(4'b1000);
    intr_in = 4'b1000;
    tick();
    intr_in = 4'b0000;
    tick();                      // rise[3] active this cycle
    instr_done = 1'b1;
    mid();
    chk("rt_id", {30'b0, int_id}, 32'd3);
    tick();
    instr_done = 1'b0;
    mid();
    chk("rt_pend_kept", {28'b0, pending}, 32'h8);
    tick();
    do_mret();
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    mid();
    chk("rt_pend_clear", {28'b0, pending}, 32'h0);
    tick();
    do_mret();

    // T6: reset in service with pending 0110, stale s1 content present
    pulse(4'b0001);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    pulse(4'b0110);
    mid();
    chk("t6_pre_pend", {28'b0, pending}, 32'h6);
    chk("t6_pre_svc", {31'b0, in_service}, 32'd1);
    tick();
    intr_in = 4'b1000;
    tick();                      // s1[3] now holds a rising line
    intr_in = 4'b0000;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    instr_done = 1'b1;
    mid();
    chk("t6_taken", {31'b0, int_taken}, 32'd0);
    chk("t6_pend", {28'b0, pending}, 32'h0);
    chk("t6_svc", {31'b0, in_service}, 32'd0);
    chk("t6_id", {30'b0, int_id}, 32'd0);
    tick(); tick(); tick();
    mid();
    chk("t6_no_spurious", {28'b0, pending}, 32'h0);
    chk("t6_no_take", {31'b0, int_taken}, 32'd0);
    tick();
    instr_done = 1'b0;

    // T5: level source on bit 0 of the second instance
    l_intr_in = 4'b0001;
    tick();                      // sampling edge k
    mid();
    chk("t5_pend_k", {28'b0, l_pending}, 32'h0);
    tick();                      // edge k+1
    mid();
    chk("t5_pend_k1", {28'b0, l_pending}, 32'h1);
    tick();
    l_instr_done = 1'b1;
    mid();
    chk("t5_taken", {31'b0, l_int_taken}, 32'd1);
    chk("t5_id", {30'b0, l_int_id}, 32'd0);
    tick();
    l_instr_done = 1'b0;
    mid();
    chk("t5_pend_stays", {28'b0, l_pending}, 32'h1);
    chk("t5_svc", {31'b0, l_in_service}, 32'd1);
    tick();
    l_intr_in = 4'b0000;
    tick();
    mid();
    chk("t5_drop_1", {28'b0, l_pending}, 32'h1);
    tick();
    mid();
    chk("t5_drop_2", {28'b0, l_pending}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
